execute_pipe: RTL and testbench

//  Parametrised 2-stage pipelined Execute unit; successor to the single-cycle Top/Execute.

---
 rtl/execute_pkg.sv | 50 +++++
 rtl/execute_if.sv | 43 ++++
 rtl/execute_alu.sv | 89 ++++++++
 rtl/execute_pipe.sv | 134 +++++++++++++
 tb/tb_execute_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/execute_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : execute_pkg
//  Description : Shared types and op codes for the pipelined Execute unit.
//                Holds the opselect classes, per-class operation codes and
//                the packed control word layout.
//  Revision    : 1.0  initial release
// ============================================================================
package execute_pkg;

    // Op classes carried in control_in[2:0]
    typedef enum logic [2:0] {
        SHIFT_REG   = 3'b000,
        ARITH_LOGIC = 3'b001,
        MEM_WRITE   = 3'b100,
        MEM_READ    = 3'b101
    } opselect_e;

    // ARITH_LOGIC operation codes
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_HADD = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_LHG  = 3'b111;

    // SHIFT_REG operation codes
    localparam logic [2:0] OP_SHLEFTLOG = 3'b000;
    localparam logic [2:0] OP_SHLEFTART = 3'b001;
    localparam logic [2:0] OP_SHRGHTLOG = 3'b010;
    localparam logic [2:0] OP_SHRGHTART = 3'b011;

    // MEM_READ operation codes
    localparam logic [2:0] OP_LOADBYTE  = 3'b000;
    localparam logic [2:0] OP_LOADHALF  = 3'b001;
    localparam logic [2:0] OP_LOADWORD  = 3'b011;
    localparam logic [2:0] OP_LOADBYTEU = 3'b100;
    localparam logic [2:0] OP_LOADHALFU = 3'b101;

    // Layout of control_in: {immp_regn, operation, opselect}
    typedef struct packed {
        logic       immp_regn;
        logic [2:0] operation;
        logic [2:0] opselect;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/execute_if.sv
`default_nettype none
// ============================================================================
//  Module      : execute_if
//  Description : Decode-side and Writeback-side bus of the Execute unit.
//                master = upstream/downstream environment, slave = pipe.
//  Revision    : 1.0  initial release
// ============================================================================
interface execute_if #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16,
    parameter int CNT_W = 16
);
    logic             enable_ex;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [IMM_W-1:0] imm;
    logic [6:0]       control_in;
    logic [WIDTH-1:0] mem_data_read_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] aluout;
    logic             carry;
    logic [WIDTH-1:0] mem_data_write_out;
    logic             mem_write_en;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output enable_ex, in_valid, src1, src2, imm, control_in,
               mem_data_read_in, out_ready,
        input  in_ready, out_valid, aluout, carry, mem_data_write_out,
               mem_write_en, retired_cnt
    );

    modport slave (
        input  enable_ex, in_valid, src1, src2, imm, control_in,
               mem_data_read_in, out_ready,
        output in_ready, out_valid, aluout, carry, mem_data_write_out,
               mem_write_en, retired_cnt
    );
endinterface
`default_nettype wire

// File: rtl/execute_alu.sv
`default_nettype none
// ============================================================================
//  Module      : execute_alu
//  Description : Combinational result/carry for one op, fed from the S1
//                registers and captured by the S2 registers.
//  Revision    : 1.0  initial release
// ============================================================================
module execute_alu
    import execute_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] aluin1,
    input  logic [WIDTH-1:0] aluin2,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic [WIDTH-1:0] mem,
    input  logic [2:0]       opselect,
    input  logic [2:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             carry
);
    localparam int HALF = WIDTH / 2;
    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0]  shift_number;
    logic             enable_shift;
    logic             enable_arith;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [HALF:0]    hi_sum;
    logic [HALF-1:0]  lo_sum;
    logic [WIDTH-1:0] addr;

    assign shift_number = aluin2[SH_W-1:0];
    assign enable_shift = (opselect == SHIFT_REG);
    assign enable_arith = (opselect == ARITH_LOGIC);

    // Full-width adder/subtractor with carry/borrow in the extra MSB
    assign sum    = {1'b0, aluin1} + {1'b0, aluin2};
    assign diff   = {1'b0, aluin1} - {1'b0, aluin2};
    // Halves are added independently; the lower carry is deliberately dropped
    assign hi_sum = {1'b0, aluin1[WIDTH-1:HALF]} + {1'b0, aluin2[WIDTH-1:HALF]};
    assign lo_sum = aluin1[HALF-1:0] + aluin2[HALF-1:0];
    // Store address always uses the immediate, whatever immp_regn says
    assign addr   = aluin1 + imm_ext;

    // Select the result by op class; unknown codes fall through to zero
    always_comb begin
        result = '0;
        carry  = 1'b0;
        if (enable_arith) begin
            case (operation)
                OP_ADD:  {carry, result} = sum;
                OP_HADD: begin
                    result = {hi_sum[HALF-1:0], lo_sum};
                    carry  = hi_sum[HALF];
                end
                OP_SUB:  {carry, result} = diff;
                OP_NOT:  result = ~aluin2;
                OP_AND:  result = aluin1 & aluin2;
                OP_OR:   result = aluin1 | aluin2;
                OP_XOR:  result = aluin1 ^ aluin2;
                OP_LHG:  result = {aluin2[HALF-1:0], {HALF{1'b0}}};
                default: result = '0;
            endcase
        end else if (enable_shift) begin
            case (operation)
                OP_SHLEFTLOG,
                OP_SHLEFTART: result = aluin1 << shift_number;
                OP_SHRGHTLOG: result = aluin1 >> shift_number;
                OP_SHRGHTART: result = $signed(aluin1) >>> shift_number;
                default:      result = '0;
            endcase
        end else if (opselect == MEM_READ) begin
            case (operation)
                OP_LOADBYTE:  result = {{(WIDTH-8){mem[7]}}, mem[7:0]};
                OP_LOADBYTEU: result = {{(WIDTH-8){1'b0}}, mem[7:0]};
                OP_LOADHALF:  result = {{HALF{mem[HALF-1]}}, mem[HALF-1:0]};
                OP_LOADHALFU: result = {{HALF{1'b0}}, mem[HALF-1:0]};
                OP_LOADWORD:  result = mem;
                default:      result = '0;
            endcase
        end else if (opselect == MEM_WRITE) begin
            result = addr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/execute_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : execute_pipe
//  Description : Two-stage pipelined Execute unit with valid/ready flow
//                control, a global freeze (enable_ex) and a saturating
//                retired-op counter. S1 holds decoded operands, S2 the result.
//  Revision    : 1.0  initial release
// ============================================================================
module execute_pipe
    import execute_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16,
    parameter int CNT_W = 16
) (
    input  logic     clock,
    input  logic     reset,
    execute_if.slave bus
);
    ctrl_t            ctrl_in;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] operand2;
    logic             adv;
    logic             accept;
    logic             retire;

    // Stage 1: decoded op and operands
    logic             s1_valid;
    logic [WIDTH-1:0] aluin1;
    logic [WIDTH-1:0] aluin2;
    logic [WIDTH-1:0] s1_imm;
    logic [WIDTH-1:0] s1_mem;
    logic [WIDTH-1:0] s1_store_data;
    logic [2:0]       opselect;
    logic [2:0]       operation;

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             s1_is_store;

    // Stage 2: result presented downstream
    logic             s2_valid;
    logic [WIDTH-1:0] s2_aluout;
    logic [WIDTH-1:0] s2_wdata;
    logic             s2_carry;
    logic             s2_store;
    logic [CNT_W-1:0] retired;

    assign ctrl_in  = ctrl_t'(bus.control_in);
    assign imm_sext = WIDTH'($signed(bus.imm));
    assign operand2 = ctrl_in.immp_regn ? imm_sext : bus.src2;

    // The whole pipe moves together: S2 empties or is taken, and not frozen
    assign adv          = bus.enable_ex & (~s2_valid | bus.out_ready);
    assign bus.in_ready = adv & reset;
    assign accept       = bus.in_valid & bus.in_ready;
    assign retire       = s2_valid & bus.out_ready & bus.enable_ex;
    assign s1_is_store  = (opselect == MEM_WRITE);

    // S1 capture: load a new op on accept, otherwise hold
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid      <= 1'b0;
            aluin1        <= '0;
            aluin2        <= '0;
            s1_imm        <= '0;
            s1_mem        <= '0;
            s1_store_data <= '0;
            opselect      <= '0;
            operation     <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                aluin1        <= bus.src1;
                aluin2        <= operand2;
                s1_imm        <= imm_sext;
                s1_mem        <= bus.mem_data_read_in;
                s1_store_data <= bus.src2;
                opselect      <= ctrl_in.opselect;
                operation     <= ctrl_in.operation;
            end
        end
    end

    execute_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .aluin1    (aluin1),
        .aluin2    (aluin2),
        .imm_ext   (s1_imm),
        .mem       (s1_mem),
        .opselect  (opselect),
        .operation (operation),
        .result    (alu_result),
        .carry     (alu_carry)
    );

    // S2 capture: take the ALU result when S1 moves forward
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_valid  <= 1'b0;
            s2_aluout <= '0;
            s2_carry  <= 1'b0;
            s2_store  <= 1'b0;
            s2_wdata  <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_aluout <= alu_result;
                s2_carry  <= alu_carry;
                s2_store  <= s1_is_store;
                s2_wdata  <= s1_is_store ? s1_store_data : '0;
            end
        end
    end

    // Count results handed downstream, sticking at all-ones
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired <= '0;
        end else if (retire && (retired != {CNT_W{1'b1}})) begin
            retired <= retired + CNT_W'(1);
        end
    end

    assign bus.out_valid          = s2_valid;
    assign bus.aluout             = s2_aluout;
    assign bus.carry              = s2_carry;
    assign bus.mem_data_write_out = s2_wdata;
    assign bus.mem_write_en       = s2_valid & s2_store;
    assign bus.retired_cnt        = retired;

endmodule
`default_nettype wire

// File: tb/tb_execute_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_pipe
//  Description : Self-checking bench for execute_pipe (WIDTH=32).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_execute_pipe;
    import execute_pkg::*;

    typedef struct packed {
        logic [31:0] aluout;
        logic        carry;
        logic [31:0] wdata;
        logic        we;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    execute_if #(.WIDTH(32), .IMM_W(16), .CNT_W(16)) bus ();

    execute_pipe #(.WIDTH(32), .IMM_W(16), .CNT_W(16)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int   checks     = 0;
    int   passes     = 0;
    int   fails      = 0;
    int   tb_retired = 0;
    exp_t expq[$];
    exp_t pend;
    bit   accepted   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] r, input logic c, input logic [31:0] w, input logic we);
        exp_t e;
        e.aluout = r; e.carry = c; e.wdata = w; e.we = we;
        return e;
    endfunction

    // Reference behaviour written directly from the op definitions
    function automatic exp_t model(input logic [6:0] ctl, input logic [31:0] a,
                                   input logic [31:0] b_reg, input logic [15:0] imm,
                                   input logic [31:0] mem);
        exp_t        r;
        logic [31:0] simm, b, lo, hi;
        logic [63:0] t;
        logic [4:0]  n;
        r    = '0;
        simm = {{16{imm[15]}}, imm};
        b    = ctl[6] ? simm : b_reg;
        n    = 5'(b % 32);
        case (ctl[2:0])
            3'b001: case (ctl[5:3])
                3'd0: begin t = {32'd0, a} + {32'd0, b}; r.aluout = t[31:0]; r.carry = (t > 64'hFFFF_FFFF); end
                3'd1: begin
                    lo = (a & 32'hFFFF) + (b & 32'hFFFF);
                    hi = (a >> 16) + (b >> 16);
                    r.aluout = (hi << 16) | (lo & 32'hFFFF);
                    r.carry  = (hi > 32'hFFFF);
                end
                3'd2: begin r.aluout = a - b; r.carry = (a < b); end
                3'd3: r.aluout = ~b;
                3'd4: r.aluout = a & b;
                3'd5: r.aluout = a | b;
                3'd6: r.aluout = a ^ b;
                default: r.aluout = b * 32'h1_0000;
            endcase
            3'b000: case (ctl[5:3])
                3'd0, 3'd1: r.aluout = a << n;
                3'd2:       r.aluout = a >> n;
                3'd3:       r.aluout = $signed(a) >>> n;
                default:    r.aluout = 32'd0;
            endcase
            3'b101: case (ctl[5:3])
                3'd0: r.aluout = (mem & 32'hFF) | (mem[7] ? 32'hFFFF_FF00 : 32'd0);
                3'd4: r.aluout = mem & 32'hFF;
                3'd1: r.aluout = (mem & 32'hFFFF) | (mem[15] ? 32'hFFFF_0000 : 32'd0);
                3'd5: r.aluout = mem & 32'hFFFF;
                3'd3: r.aluout = mem;
                default: r.aluout = 32'd0;
            endcase
            3'b100: begin r.aluout = a + simm; r.wdata = b_reg; r.we = 1'b1; end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [6:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, input logic [31:0] mem);
        bus.control_in       = ctl;
        bus.src1             = a;
        bus.src2             = b;
        bus.imm              = imm;
        bus.mem_data_read_in = mem;
    endtask

    // Negedge observation: scoreboard retire, hold check, and accept tracking
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (bus.out_valid && !(bus.out_ready && bus.enable_ex) && expq.size() > 0)
            check("hold_aluout", 64'(bus.aluout), 64'(expq[0].aluout));
        if (bus.out_valid && bus.out_ready && bus.enable_ex) begin
            if (expq.size() == 0) begin
                check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                e = expq.pop_front();
                tb_retired++;
                check("aluout", 64'(bus.aluout), 64'(e.aluout));
                check("carry", 64'(bus.carry), 64'(e.carry));
                check("mem_data_write_out", 64'(bus.mem_data_write_out), 64'(e.wdata));
                check("mem_write_en", 64'(bus.mem_write_en), 64'(e.we));
            end
        end
        accepted = bus.in_valid && bus.in_ready && bus.enable_ex;
        if (accepted) expq.push_back(pend);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, input logic [31:0] mem, input exp_t e);
        drive(ctl, a, b, imm, mem);
        pend         = e;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample();
            if (accepted) break;
            advance();
        end
        if (!accepted) check("accept_timeout", 64'(bus.in_ready), 64'd1);
        advance();
        bus.in_valid = 1'b0;
    endtask

    task automatic issue_m(input logic [6:0] ctl, input logic [31:0] a, input logic [31:0] b,
                           input logic [15:0] imm, input logic [31:0] mem);
        issue(ctl, a, b, imm, mem, model(ctl, a, b, imm, mem));
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.enable_ex = 1'b1;
        for (int i = 0; i < 30 && expq.size() > 0; i++) begin
            sample();
            advance();
        end
        check("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    function automatic logic [6:0] cw(input logic immp, input logic [2:0] op, input logic [2:0] sel);
        return {immp, op, sel};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0]  rc;
        logic [2:0]  rsel;
        logic [31:0] ra, rb, rm;
        logic [15:0] ri;
        int          issued;

        bus.enable_ex = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(7'd0, 32'd0, 32'd0, 16'd0, 32'd0);

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_aluout", 64'(bus.aluout), 64'd0);
        check("rst_mem_write_en", 64'(bus.mem_write_en), 64'd0);
        check("rst_retired_cnt", 64'(bus.retired_cnt), 64'd0);
        #2 rst_n = 1'b1;
        advance();

        // ADD with carry out and 2-clock latency
        drive(cw(1'b0, OP_ADD, ARITH_LOGIC), 32'hFFFF_FFFF, 32'd1, 16'd0, 32'd0);
        pend = mk(32'h0, 1'b1, 32'h0, 1'b0);
        bus.in_valid = 1'b1;
        sample();
        check("t1_in_ready", 64'(bus.in_ready), 64'd1);
        advance();
        bus.in_valid = 1'b0;
        sample();
        check("t1_not_yet_valid", 64'(bus.out_valid), 64'd0);
        advance();
        sample();
        check("t1_out_valid", 64'(bus.out_valid), 64'd1);
        advance();

        // Directed ops with known results
        issue(cw(1'b1, OP_SUB, ARITH_LOGIC), 32'd5, 32'd0, 16'd7, 32'd0, mk(32'hFFFF_FFFE, 1'b1, 32'd0, 1'b0));
        issue(cw(1'b0, OP_HADD, ARITH_LOGIC), 32'h0001_FFFF, 32'h0001_0001, 16'd0, 32'd0, mk(32'h0002_0000, 1'b0, 32'd0, 1'b0));
        issue(cw(1'b0, OP_SHRGHTART, SHIFT_REG), 32'h8000_0000, 32'd4, 16'd0, 32'd0, mk(32'hF800_0000, 1'b0, 32'd0, 1'b0));
        issue(cw(1'b0, OP_SHRGHTLOG, SHIFT_REG), 32'h8000_0000, 32'd4, 16'd0, 32'd0, mk(32'h0800_0000, 1'b0, 32'd0, 1'b0));
        issue(cw(1'b0, OP_SHLEFTLOG, SHIFT_REG), 32'h1234_5678, 32'd32, 16'd0, 32'd0, mk(32'h1234_5678, 1'b0, 32'd0, 1'b0));
        issue(cw(1'b0, OP_LOADBYTE, MEM_READ), 32'd0, 32'd0, 16'd0, 32'h0000_8080, mk(32'hFFFF_FF80, 1'b0, 32'd0, 1'b0));
        issue(cw(1'b0, OP_LOADBYTEU, MEM_READ), 32'd0, 32'd0, 16'd0, 32'h0000_8080, mk(32'h0000_0080, 1'b0, 32'd0, 1'b0));
        issue(cw(1'b0, OP_LOADHALF, MEM_READ), 32'd0, 32'd0, 16'd0, 32'h0000_8080, mk(32'hFFFF_8080, 1'b0, 32'd0, 1'b0));
        issue(cw(1'b1, 3'd0, MEM_WRITE), 32'h100, 32'hAB, 16'hFFFC, 32'd0, mk(32'h0000_00FC, 1'b0, 32'hAB, 1'b1));
        issue(cw(1'b0, OP_LHG, ARITH_LOGIC), 32'd0, 32'h0000_BEEF, 16'd0, 32'd0, mk(32'hBEEF_0000, 1'b0, 32'd0, 1'b0));
        issue(cw(1'b0, 3'd0, 3'b111), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd0, 32'd0, mk(32'd0, 1'b0, 32'd0, 1'b0));
        drain();

        // Four back-to-back ops with a 3-clock downstream stall after the first result
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        expq.delete();
        tb_retired = 0;
        advance();
        issued = 0;
        for (int c = 0; c < 40 && tb_retired < 4; c++) begin
            if (issued < 4) begin
                ra = $urandom; rb = $urandom; ri = 16'($urandom); rm = $urandom;
                rc = cw(1'($urandom), 3'(issued), ARITH_LOGIC);
                drive(rc, ra, rb, ri, rm);
                pend = model(rc, ra, rb, ri, rm);
            end
            bus.in_valid  = (issued < 4);
            bus.out_ready = !(c >= 2 && c <= 4);
            sample();
            if (c >= 2 && c <= 4) begin
                check("s5_in_ready_full", 64'(bus.in_ready), 64'd0);
                check("s5_out_valid_held", 64'(bus.out_valid), 64'd1);
            end
            if (accepted) issued++;
            advance();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("s5_queue_empty", 64'(expq.size()), 64'd0);
        check("s5_retired_cnt", 64'(bus.retired_cnt), 64'd4);

        // enable_ex=0 for 2 clocks freezes the pipe
        drive(cw(1'b0, OP_XOR, ARITH_LOGIC), 32'hF0F0_1234, 32'h0FF0_4321, 16'd0, 32'd0);
        pend = model(cw(1'b0, OP_XOR, ARITH_LOGIC), 32'hF0F0_1234, 32'h0FF0_4321, 16'd0, 32'd0);
        bus.in_valid = 1'b1;
        sample();
        advance();
        drive(cw(1'b0, OP_OR, ARITH_LOGIC), 32'h0000_00F0, 32'h0F00_000F, 16'd0, 32'd0);
        pend = model(cw(1'b0, OP_OR, ARITH_LOGIC), 32'h0000_00F0, 32'h0F00_000F, 16'd0, 32'd0);
        sample();
        advance();
        drive(cw(1'b0, OP_NOT, ARITH_LOGIC), 32'd0, 32'h5555_AAAA, 16'd0, 32'd0);
        pend = model(cw(1'b0, OP_NOT, ARITH_LOGIC), 32'd0, 32'h5555_AAAA, 16'd0, 32'd0);
        bus.enable_ex = 1'b0;
        for (int c = 0; c < 2; c++) begin
            sample();
            check("frz_in_ready", 64'(bus.in_ready), 64'd0);
            check("frz_out_valid", 64'(bus.out_valid), 64'd1);
            check("frz_retired_cnt", 64'(bus.retired_cnt), 64'(tb_retired));
            advance();
        end
        bus.enable_ex = 1'b1;
        issue_m(cw(1'b0, OP_NOT, ARITH_LOGIC), 32'd0, 32'h5555_AAAA, 16'd0, 32'd0);
        drain();

        // Asynchronous reset with two ops in flight
        bus.out_ready = 1'b0;
        drive(cw(1'b1, 3'd0, MEM_WRITE), 32'h2000, 32'hCAFE_F00D, 16'h0010, 32'd0);
        pend = model(cw(1'b1, 3'd0, MEM_WRITE), 32'h2000, 32'hCAFE_F00D, 16'h0010, 32'd0);
        bus.in_valid = 1'b1;
        sample();
        advance();
        drive(cw(1'b0, OP_ADD, ARITH_LOGIC), 32'd1, 32'd2, 16'd0, 32'd0);
        pend = model(cw(1'b0, OP_ADD, ARITH_LOGIC), 32'd1, 32'd2, 16'd0, 32'd0);
        sample();
        advance();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_aluout", 64'(bus.aluout), 64'd0);
        check("arst_carry", 64'(bus.carry), 64'd0);
        check("arst_mem_write_en", 64'(bus.mem_write_en), 64'd0);
        check("arst_mem_data_write_out", 64'(bus.mem_data_write_out), 64'd0);
        check("arst_retired_cnt", 64'(bus.retired_cnt), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd0);
        expq.delete();
        tb_retired = 0;
        #3 rst_n = 1'b1;
        advance();
        bus.out_ready = 1'b1;
        issue_m(cw(1'b0, OP_AND, ARITH_LOGIC), 32'hFF00_FF00, 32'h0FF0_0FF0, 16'd0, 32'd0);
        drain();
        check("post_rst_retired_cnt", 64'(bus.retired_cnt), 64'(tb_retired));

        // Randomised traffic with random stalls and freezes
        issued = 0;
        for (int c = 0; c < 600 && (issued < 60 || expq.size() > 0); c++) begin
            if (!bus.in_valid || accepted) begin
                case ($urandom_range(0, 4))
                    0:       rsel = SHIFT_REG;
                    1:       rsel = ARITH_LOGIC;
                    2:       rsel = MEM_READ;
                    3:       rsel = MEM_WRITE;
                    default: rsel = 3'($urandom);
                endcase
                rc = cw(1'($urandom), 3'($urandom), rsel);
                ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                rb = $urandom; ri = 16'($urandom); rm = $urandom;
                drive(rc, ra, rb, ri, rm);
                pend = model(rc, ra, rb, ri, rm);
            end
            bus.in_valid  = (issued < 60);
            bus.enable_ex = ($urandom_range(0, 9) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            sample();
            if (accepted) issued++;
            advance();
        end
        drain();
        check("rand_retired_cnt", 64'(bus.retired_cnt), 64'(tb_retired));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
